// File: rtl/cpu_run_monitor_if.sv
// ----------------------------------------------------------------------------
// cpu_run_monitor_if
// Bundles the run-monitor's control and observation signals.
//   restart     : synchronous pulse, rerun the core from its reset sequence
//   pc          : core program counter (observed)
//   alu_result  : core ALU output (observed)
//   cpu_rst     : reset to the core, active-high
//   running     : core is executing
//   halted      : PC self-loop detected
//   timeout     : cycle budget exhausted
//   done        : halted | timeout
//   pass        : halted with the expected signature
//   cycle_count : executed cycles of the current run
//   signature   : rotate-xor fold of every ALU result of the current run
// master = the run monitor, slave = the harness that owns restart/pc/alu.
// ----------------------------------------------------------------------------
interface cpu_run_monitor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             restart;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  alu_result;
    logic             cpu_rst;
    logic             running;
    logic             halted;
    logic             timeout;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] cycle_count;
    logic [XLEN-1:0]  signature;

    modport master (
        input  restart, pc, alu_result,
        output cpu_rst, running, halted, timeout, done, pass, cycle_count, signature
    );

    modport slave (
        output restart, pc, alu_result,
        input  cpu_rst, running, halted, timeout, done, pass, cycle_count, signature
    );
endinterface

// File: rtl/cpu_run_monitor.sv
// ----------------------------------------------------------------------------
// cpu_run_monitor
// Run controller and checker placed beside the CPU core. It sequences the
// core reset, counts executed cycles, detects completion (PC stuck on the
// same value for HALT_CYCLES consecutive comparisons) or a cycle-budget
// timeout, and folds every ALU result into a running signature.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : cpu_run_monitor_if.master (restart/pc/alu_result in,
//          cpu_rst/status/cycle_count/signature out)
// ----------------------------------------------------------------------------
module cpu_run_monitor #(
    parameter int              XLEN         = 32,
    parameter int              CNT_W        = 32,
    parameter int              RESET_CYCLES = 5,
    parameter int              HALT_CYCLES  = 4,
    parameter int              MAX_CYCLES   = 200000,
    parameter logic [XLEN-1:0] EXPECT_SIG   = '0
) (
    input  logic               clk,
    input  logic               rst,
    cpu_run_monitor_if.master  bus
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int STAB_W = $clog2(HALT_CYCLES + 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [HOLD_W-1:0] hold_cnt;
    logic [STAB_W-1:0] stable_cnt;
    logic [CNT_W-1:0]  cycle_count;
    logic [XLEN-1:0]   signature;
    logic [XLEN-1:0]   pc_prev;
    logic              pc_valid;

    logic              pc_same;
    logic              halt_hit;
    logic              budget_hit;
    logic              hold_done;

    function automatic logic [XLEN-1:0] rotl1(input logic [XLEN-1:0] v);
        return {v[XLEN-2:0], v[XLEN-1]};
    endfunction

    // pc_valid masks the first RUN edge, where pc_prev holds stale data.
    assign pc_same    = pc_valid && (bus.pc == pc_prev);
    assign halt_hit   = (state == RUN) && pc_same &&
                        (stable_cnt == STAB_W'(HALT_CYCLES - 1));
    assign budget_hit = (state == RUN) && (cycle_count == CNT_W'(MAX_CYCLES - 1));
    assign hold_done  = (hold_cnt == HOLD_W'(RESET_CYCLES - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HOLD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; restart overrides everything, halt beats timeout.
    always_comb begin
        next_state = state;
        if (bus.restart) begin
            next_state = HOLD;
        end else begin
            case (state)
                HOLD:    if (hold_done) next_state = RUN;
                RUN: begin
                    if (halt_hit)        next_state = HALTED;
                    else if (budget_hit) next_state = TIMEOUT;
                end
                default: next_state = state;
            endcase
        end
    end

    // Outputs decoded from the state register
    always_comb begin
        bus.cpu_rst = (state == HOLD);
        bus.running = (state == RUN);
        bus.halted  = (state == HALTED);
        bus.timeout = (state == TIMEOUT);
        bus.done    = (state == HALTED) || (state == TIMEOUT);
        bus.pass    = (state == HALTED) && (signature == EXPECT_SIG);
    end

    assign bus.cycle_count = cycle_count;
    assign bus.signature   = signature;

    // Run bookkeeping; everything freezes once a terminal state is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt    <= '0;
            cycle_count <= '0;
            signature   <= '0;
            stable_cnt  <= '0;
            pc_valid    <= 1'b0;
        end else if (bus.restart) begin
            hold_cnt    <= '0;
            cycle_count <= '0;
            signature   <= '0;
            stable_cnt  <= '0;
            pc_valid    <= 1'b0;
        end else begin
            case (state)
                HOLD: hold_cnt <= hold_cnt + 1'b1;
                RUN: begin
                    cycle_count <= cycle_count + 1'b1;
                    signature   <= rotl1(signature) ^ bus.alu_result;
                    pc_valid    <= 1'b1;
                    stable_cnt  <= pc_same ? stable_cnt + 1'b1 : '0;
                end
                default: ;
            endcase
        end
    end

    // pc_prev is only meaningful when pc_valid is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!bus.restart && (state == RUN)) begin
            pc_prev <= bus.pc;
        end
    end

endmodule

// File: tb/tb_cpu_run_monitor.sv
module tb_cpu_run_monitor;

    localparam int          XLEN         = 32;
    localparam int          CNT_W        = 32;
    localparam int          RESET_CYCLES = 5;
    localparam int          HALT_CYCLES  = 4;
    localparam int          MAX_CYCLES   = 20;
    localparam logic [31:0] EXPECT_SIG   = 32'h0000_00FF;

    localparam int M_HOLD = 0, M_RUN = 1, M_HALT = 2, M_TO = 3;

    typedef struct {
        logic        cpu_rst, running, halted, timeout, done, pass;
        logic [31:0] cnt;
        logic [31:0] sig;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_run_monitor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    cpu_run_monitor #(
        .XLEN(XLEN), .CNT_W(CNT_W), .RESET_CYCLES(RESET_CYCLES),
        .HALT_CYCLES(HALT_CYCLES), .MAX_CYCLES(MAX_CYCLES), .EXPECT_SIG(EXPECT_SIG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference model: tracks the run in terms of edges seen and PC history.
    int          m_mode;
    int          m_hold;
    int          m_cycles;
    logic [31:0] m_sig;
    logic [31:0] m_hist[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_HOLD; m_hold = 0; m_cycles = 0; m_sig = '0; m_hist.delete();
    endtask

    function automatic bit halt_seen();
        int n = m_hist.size();
        if (n < HALT_CYCLES + 1) return 1'b0;
        for (int k = 1; k <= HALT_CYCLES; k++)
            if (m_hist[n-1-k] != m_hist[n-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input logic r, input logic [31:0] p, input logic [31:0] a);
        if (r) begin
            model_reset();
        end else if (m_mode == M_HOLD) begin
            m_hold++;
            if (m_hold == RESET_CYCLES) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            m_cycles++;
            m_sig = ((m_sig << 1) | (m_sig >> 31)) ^ a;
            m_hist.push_back(p);
            if (halt_seen())                m_mode = M_HALT;
            else if (m_cycles == MAX_CYCLES) m_mode = M_TO;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.cpu_rst = (m_mode == M_HOLD);
        e.running = (m_mode == M_RUN);
        e.halted  = (m_mode == M_HALT);
        e.timeout = (m_mode == M_TO);
        e.done    = (m_mode == M_HALT) || (m_mode == M_TO);
        e.pass    = (m_mode == M_HALT) && (m_sig == EXPECT_SIG);
        e.cnt     = m_cycles;
        e.sig     = m_sig;
        return e;
    endfunction

    // Drive one edge's inputs and queue the expected state after that edge.
    task automatic step(input logic r, input logic [31:0] p, input logic [31:0] a);
        @(negedge clk);
        bus.restart    = r;
        bus.pc         = p;
        bus.alu_result = a;
        model_step(r, p, a);
        exp_q.push_back(model_out());
    endtask

    // Wait for the edge of the last queued step, then settle.
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic hold_seq();
        for (int i = 0; i < RESET_CYCLES; i++) step(1'b0, 32'h0, 32'h0);
    endtask

    // Asserts rst between edges and checks the asynchronous response.
    task automatic async_reset_check();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        chk("async_running", 64'(bus.running), 64'd0);
        chk("async_done",    64'(bus.done),    64'd0);
        chk("async_count",   64'(bus.cycle_count), 64'd0);
        chk("async_sig",     64'(bus.signature),   64'd0);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Scoreboard monitor: compares every edge for which an expectation exists.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_cpu_rst", 64'(bus.cpu_rst), 64'(e.cpu_rst));
            chk("sb_running", 64'(bus.running), 64'(e.running));
            chk("sb_halted",  64'(bus.halted),  64'(e.halted));
            chk("sb_timeout", 64'(bus.timeout), 64'(e.timeout));
            chk("sb_done",    64'(bus.done),    64'(e.done));
            chk("sb_pass",    64'(bus.pass),    64'(e.pass));
            chk("sb_count",   64'(bus.cycle_count), 64'(e.cnt));
            chk("sb_sig",     64'(bus.signature),   64'(e.sig));
        end
    end

    initial begin
        logic [31:0] pcv;
        bus.restart = 1'b0; bus.pc = '0; bus.alu_result = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        chk("rst_running", 64'(bus.running), 64'd0);
        chk("rst_halted",  64'(bus.halted),  64'd0);
        chk("rst_timeout", 64'(bus.timeout), 64'd0);
        chk("rst_done",    64'(bus.done),    64'd0);
        chk("rst_pass",    64'(bus.pass),    64'd0);
        chk("rst_count",   64'(bus.cycle_count), 64'd0);
        chk("rst_sig",     64'(bus.signature),   64'd0);
        rst = 1'b0;

        // Reset sequence
        for (int i = 0; i < RESET_CYCLES - 1; i++) step(1'b0, 32'h0, 32'h0);
        after_edge();
        chk("hold_cpu_rst_before_last", 64'(bus.cpu_rst), 64'd1);
        step(1'b0, 32'h0, 32'h0);
        after_edge();
        chk("run_entry_running", 64'(bus.running), 64'd1);
        chk("run_entry_cpu_rst", 64'(bus.cpu_rst), 64'd0);
        chk("run_entry_count",   64'(bus.cycle_count), 64'd0);

        // Signature folding
        step(1'b0, 32'h0, 32'h1);
        after_edge();
        chk("sig_1", 64'(bus.signature), 64'h1);
        step(1'b0, 32'h4, 32'h1);
        after_edge();
        chk("sig_3", 64'(bus.signature), 64'h3);
        step(1'b0, 32'h8, 32'h8000_0000);
        after_edge();
        chk("sig_rot", 64'(bus.signature), 64'h8000_0006);

        // Halt on PC self-loop; alu=1 every edge folds to 0xFF
        step(1'b1, 32'h0, 32'h0);
        hold_seq();
        for (int i = 0; i < 8; i++) step(1'b0, (i < 4) ? 32'(4 * i) : 32'd12, 32'h1);
        after_edge();
        chk("halt_halted", 64'(bus.halted), 64'd1);
        chk("halt_count",  64'(bus.cycle_count), 64'd8);
        chk("halt_pass",   64'(bus.pass), 64'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h40, 32'h5);

        // Restart from HALTED
        step(1'b1, 32'h0, 32'h0);
        after_edge();
        chk("restart_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        chk("restart_count",   64'(bus.cycle_count), 64'd0);
        chk("restart_sig",     64'(bus.signature),   64'd0);
        hold_seq();

        // Timeout: PC never repeats; counters freeze afterwards
        for (int i = 0; i < MAX_CYCLES; i++) step(1'b0, 32'(4 * i), $urandom);
        after_edge();
        chk("to_timeout", 64'(bus.timeout), 64'd1);
        chk("to_count",   64'(bus.cycle_count), 64'd20);
        chk("to_pass",    64'(bus.pass), 64'd0);
        for (int i = 0; i < 10; i++) step(1'b0, $urandom, $urandom);
        after_edge();
        chk("to_frozen_count", 64'(bus.cycle_count), 64'd20);

        // Restart coinciding with the halt condition
        step(1'b1, 32'h0, 32'h0);
        hold_seq();
        step(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h4, 32'h2);
        step(1'b1, 32'h4, 32'h2);
        after_edge();
        chk("restart_vs_halt_halted",  64'(bus.halted),  64'd0);
        chk("restart_vs_halt_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0, 32'h0);
        hold_seq();

        // Async reset mid-run
        for (int i = 0; i < 3; i++) step(1'b0, 32'(4 * i), $urandom);
        async_reset_check();

        // Randomized phase
        pcv = '0;
        for (int n = 0; n < 600; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 2) begin
                async_reset_check();
            end else begin
                if ($urandom_range(0, 1) == 0) pcv = 32'($urandom_range(0, 3) * 4);
                step(r < 5, pcv, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Synthesizable run controller and checker that wraps the CPU core for simulation and FPGA bring-up. It generates the core's reset sequence and counts executed cycles. It detects program completion (PC self-loop) or a cycle-budget timeout, and folds every ALU result into a running signature for pass/fail comparison. It sits beside `cpu_top`, driving the core's reset and observing its `pc` and `alu_result` buses.

## Interface
- `XLEN`, 32: width of `pc`, `alu_result`, `signature`.
- `CNT_W`, 32: width of `cycle_count`; `MAX_CYCLES` must be < 2^CNT_W.
- `RESET_CYCLES`, 5: cycles `cpu_rst` is held after reset/restart; ≥1.
- `HALT_CYCLES`, 4: consecutive equal-PC comparisons that mean halted; ≥1.
- `MAX_CYCLES`, 200000: run-cycle budget before timeout; ≥2.
- `EXPECT_SIG`, 0: golden signature for `pass`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `restart`  in  1  synchronous pulse: rerun from reset sequence.
- `pc`  in  XLEN  core program counter.
- `alu_result`  in  XLEN  core ALU output.
- `cpu_rst`  out  1  reset to core, active-high.
- `running`  out  1  high in RUN.
- `halted`  out  1  high in HALTED.
- `timeout`  out  1  high in TIMEOUT.
- `done`  out  1  `halted | timeout`.
- `pass`  out  1  `halted && signature == EXPECT_SIG`.
- `cycle_count`  out  CNT_W  RUN cycles elapsed.
- `signature`  out  XLEN  ALU result signature.

## Operation
- States: HOLD, RUN, HALTED, TIMEOUT. All outputs are registered or decoded from the state register.
- Reset (`rst`=1, async) sets: state HOLD, `cpu_rst`=1, hold counter 0, `cycle_count`=0, `signature`=0, stable counter 0, `pc_valid`=0. It therefore sets `running`/`halted`/`timeout`/`done`/`pass`=0.
- HOLD:
  - Hold counter increments every edge.
  - At the edge where the counter equals RESET_CYCLES-1: state goes to RUN and `cpu_rst` goes to 0.
- RUN, per edge:
  - `cycle_count` += 1.
  - `signature` <= rotl1(`signature`) ^ `alu_result`.
  - `pc_prev` <= `pc` and `pc_valid` <= 1.
  - If `pc_valid` and `pc == pc_prev`: stable counter += 1; otherwise the stable counter is 0.
- Halt: in RUN, when `pc_valid`, `pc == pc_prev`, and stable counter == HALT_CYCLES-1, the next state is HALTED.
- Timeout: in RUN, when `cycle_count` == MAX_CYCLES-1 and the halt condition is false, the next state is TIMEOUT.
- Simultaneous halt and timeout: halt wins.
- HALTED/TIMEOUT are terminal:
  - `cycle_count`, `signature` and the stable counter freeze.
  - `cpu_rst` stays 0.
  - The state is left only by `rst` or `restart`.
- `restart`=1 at an edge in any state:
  - Next state is HOLD; `cpu_rst` goes to 1.
  - Hold counter, `cycle_count`, `signature`, stable counter and `pc_valid` are cleared.
  - `restart` has priority over halt and timeout, and over the counter updates at that edge.
  - `restart` held high keeps the block in HOLD.
- `rst` asserted mid-run: immediate asynchronous return to the reset values, without waiting for an edge.

## Timing
- After `rst` falls, `cpu_rst` stays 1 for exactly RESET_CYCLES rising edges and is 0 after the RESET_CYCLES-th edge.
- `restart` sampled at edge E: `cpu_rst`=1 after E. The HOLD sequence then repeats, so `cpu_rst`=0 after edge E+RESET_CYCLES.
- `signature` and `cycle_count` reflect the inputs sampled up to and including the previous edge; latency is 1.
- Halt declared after the edge of the HALT_CYCLES-th consecutive equal comparison. Minimum RUN length to halt is HALT_CYCLES+1 edges, because the first RUN edge only loads `pc_prev`.
- Final `cycle_count` at halt includes the halting edge. At timeout, `cycle_count` = MAX_CYCLES.
- `done`/`pass` are valid the same cycle that the state becomes terminal.

## Test plan
Bench parameters: RESET_CYCLES=5, HALT_CYCLES=4, MAX_CYCLES=20, XLEN=32.

1. Reset sequence: release `rst` → `cpu_rst`=1 for 5 edges, then 0 and `running`=1. `cycle_count`=0 and `signature`=0 at RUN entry.
2. Signature: in RUN, `alu_result`=1 for 2 edges → `signature`=1, then 3. With `alu_result`=0x80000000 on the next edge → 0x80000006.
3. Halt: `pc` = 0,4,8,12, then held at 12 → `halted`=1 after the 4th equal comparison, `cycle_count`=8. `pass`=1 only if EXPECT_SIG matches the captured `signature`.
4. Timeout: `pc` increments by 4 every edge → `timeout`=1, `cycle_count`=20, `pass`=0. Counters stay frozen for 10 more edges.
5. Restart: pulse `restart` in HALTED → `cpu_rst`=1 next cycle, all counters 0, 5-edge HOLD, then RUN. Pulse `restart` in the same cycle as the halt condition → HOLD, not HALTED.
6. Async reset: assert `rst` between edges mid-RUN → `cpu_rst`=1 and `running`=0 before the next edge; `cycle_count`=0.
